// File: rtl/bit_serial_adder.sv
// bit_serial_adder: LSB-first serial a+b+cin over WIDTH cycles; ports in_valid/in_ready/a/b/cin in, out_valid/out_ready/sum/cout out, busy, clk, rst_n (sync active-low)
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             s, c;
  logic [WIDTH:0]   sh;
  always_comb begin
    s       = a_q[0] ^ b_q[0] ^ carry_q;
    c       = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    sh      = {s, sum_q} >> 1;
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a;
        b_d     = b;
        carry_d = cin;
        cnt_d   = '0;
        sum_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = sh[WIDTH-1:0];
        carry_d = c;
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(WIDTH - 1)) ? DONE : RUN;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign sum       = sum_q;
  assign cout      = carry_q;
endmodule

// File: tb/tb_bit_serial_adder.sv
// tb_bit_serial_adder: random and directed checks of bit_serial_adder at WIDTH=8 and WIDTH=1 against a+b+cin
module tb_bit_serial_adder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iv8 = 1'b0, ir8, ov8, or8 = 1'b0, cin8 = 1'b0, co8, bz8;
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic       iv1 = 1'b0, ir1, ov1, or1 = 1'b0, cin1 = 1'b0, co1, bz1;
  logic [0:0] a1 = '0, b1 = '0, s1;
  int         total = 0, bad = 0;
  bit         hi;
  bit [7:0]   ps;
  bit         pc;
  bit [7:0]   rx, ry;
  bit         rc;
  bit_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8),
    .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .busy(bz8)
  );
  bit_serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(cin1),
    .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1), .busy(bz1)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic g_ir(input bit one); return one ? ir1 : ir8; endfunction
  function automatic logic g_ov(input bit one); return one ? ov1 : ov8; endfunction
  function automatic logic g_bz(input bit one); return one ? bz1 : bz8; endfunction
  function automatic logic [7:0] g_sum(input bit one); return one ? {7'd0, s1} : s8; endfunction
  function automatic logic g_co(input bit one); return one ? co1 : co8; endfunction
  task automatic drive(input bit one, input logic v, input logic [7:0] x, input logic [7:0] y, input logic c);
    if (one) begin
      iv1 = v; a1 = x[0]; b1 = y[0]; cin1 = c;
    end else begin
      iv8 = v; a8 = x; b8 = y; cin8 = c;
    end
  endtask
  task automatic set_ordy(input bit one, input logic r);
    if (one) or1 = r; else or8 = r;
  endtask
  task automatic do_op(input bit one, input logic [7:0] x, input logic [7:0] y, input logic c, input int hold);
    logic [8:0] want;
    int n;
    want = one ? 9'(x[0]) + 9'(y[0]) + 9'(c) : {1'b0, x} + {1'b0, y} + 9'(c);
    if (one) want = {7'd0, want[1], want[0]};
    set_ordy(one, 1'b0);
    n = 0;
    while (!g_ir(one) && n < 20) begin tick; n++; end
    drive(one, 1'b1, x, y, c);
    tick;
    drive(one, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    chk("in_ready_fall", 32'(g_ir(one)), 32'd0);
    chk("busy_run", 32'(g_bz(one)), 32'd1);
    n = 0;
    do begin tick; n++; end while (!g_ov(one) && n < 40);
    chk("latency", n, one ? 1 : 8);
    chk("sum", 32'(g_sum(one)), 32'(one ? {7'd0, want[0]} : want[7:0]));
    chk("cout", 32'(g_co(one)), 32'(one ? want[1] : want[8]));
    for (int i = 0; i < hold; i++) begin
      drive(one, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
      tick;
      chk("bp_valid", 32'(g_ov(one)), 32'd1);
      chk("bp_sum", 32'(g_sum(one)), 32'(one ? {7'd0, want[0]} : want[7:0]));
      chk("bp_cout", 32'(g_co(one)), 32'(one ? want[1] : want[8]));
      chk("bp_in_ready", 32'(g_ir(one)), 32'd0);
    end
    drive(one, 1'b0, 8'd0, 8'd0, 1'b0);
    set_ordy(one, 1'b1);
    tick;
    set_ordy(one, 1'b0);
    chk("idle_in_ready", 32'(g_ir(one)), 32'd1);
    chk("idle_out_valid", 32'(g_ov(one)), 32'd0);
  endtask
  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      iv8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); or8 = 1'($urandom);
      iv1 = 1'($urandom); a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom); or1 = 1'($urandom);
      tick;
    end
    chk("rst_in_ready", 32'(ir8), 32'd1);
    chk("rst_out_valid", 32'(ov8), 32'd0);
    chk("rst_busy", 32'(bz8), 32'd0);
    chk("rst_sum", 32'(s8), 32'h00);
    chk("rst_cout", 32'(co8), 32'd0);
    chk("rst1_in_ready", 32'(ir1), 32'd1);
    chk("rst1_out_valid", 32'(ov1), 32'd0);
    drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    drive(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    or8 = 1'b0; or1 = 1'b0;
    rst_n = 1'b1;
    tick;
    chk("post_rst_in_ready", 32'(ir8), 32'd1);
    do_op(1'b0, 8'hFF, 8'h01, 1'b0, 0);
    do_op(1'b0, 8'h00, 8'h00, 1'b0, 0);
    do_op(1'b0, 8'hFF, 8'hFF, 1'b1, 0);
    do_op(1'b0, 8'hA5, 8'h5A, 1'b0, 0);
    do_op(1'b0, 8'h3C, 8'h81, 1'b1, 5);
    do_op(1'b0, 8'h12, 8'h34, 1'b0, 0);
    drive(1'b0, 1'b1, 8'h77, 8'h99, 1'b1);
    tick;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    tick; tick; tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("midrst_in_ready", 32'(ir8), 32'd1);
    chk("midrst_out_valid", 32'(ov8), 32'd0);
    chk("midrst_busy", 32'(bz8), 32'd0);
    hi = 1'b0;
    or8 = 1'b1;
    for (int i = 0; i < 12; i++) begin tick; hi |= ov8; end
    or8 = 1'b0;
    chk("midrst_no_valid", 32'(hi), 32'd0);
    do_op(1'b0, 8'h10, 8'h20, 1'b1, 0);
    for (int i = 0; i < 1000; i++) begin
      rx = 8'($urandom); ry = 8'($urandom); rc = 1'($urandom);
      do_op(1'b0, rx, ry, rc, (i % 97 == 0) ? 2 : 0);
    end
    for (int i = 0; i < 8; i++) begin
      ps = 8'(i);
      do_op(1'b1, {7'd0, ps[2]}, {7'd0, ps[1]}, ps[0], 0);
    end
    do_op(1'b1, 8'd1, 8'd1, 1'b1, 3);
    pc = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
